// File: rtl/fir_poly_sched.sv
// fir_poly_sched: sequencer for a polyphase decimating FIR on one shared DSP.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   din_valid / din_ready   sample strobe / controller idle
//   mac_en, tap_addr        MAC operand valid, tap index in bank
//   coef_addr, dsp_acc      coefficient ROM address, 0=load 1=accumulate
//   phase                   phase of current sample
//   capture, dout_valid     output register load, decimated output valid
//   overrun, overrun_clr    sticky dropped-sample flag and its clear
module fir_poly_sched #(
    parameter int N_TAPS   = 120,
    parameter int M        = 20,
    parameter int BANK_LEN = 6,
    parameter int DSP_LAT  = 3,
    localparam int M_LOG2  = (M > 1) ? $clog2(M) : 1,
    localparam int BL_LOG2 = (BANK_LEN > 1) ? $clog2(BANK_LEN) : 1,
    localparam int NT_LOG2 = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din_valid,
    output logic               din_ready,
    output logic               mac_en,
    output logic [BL_LOG2-1:0] tap_addr,
    output logic [NT_LOG2-1:0] coef_addr,
    output logic               dsp_acc,
    output logic [M_LOG2-1:0]  phase,
    output logic               capture,
    output logic               dout_valid,
    output logic               overrun,
    input  logic               overrun_clr
);

    localparam int WL_W = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;

    localparam logic [BL_LOG2-1:0] LAST_TAP = BL_LOG2'(BANK_LEN - 1);
    localparam logic [M_LOG2-1:0]  LAST_PH  = M_LOG2'(M - 1);
    localparam logic [WL_W-1:0]    LAST_W   = WL_W'(DSP_LAT - 1);
    localparam logic [NT_LOG2-1:0] BASE_INC = NT_LOG2'(BANK_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t               state_q, state_d;
    logic [BL_LOG2-1:0]   tap_q, tap_d;
    logic [NT_LOG2-1:0]   base_q, base_d;
    logic [M_LOG2-1:0]    phase_q, phase_d;
    logic [WL_W-1:0]      wait_q, wait_d;
    logic                 ready_q, mac_en_q, acc_q;
    logic                 capture_q, dout_valid_q, overrun_q;
    logic                 ovr_set;

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        base_d  = base_q;
        phase_d = phase_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    state_d = S_MAC;
                    tap_d   = '0;
                end
            end
            S_MAC: begin
                if (tap_q == LAST_TAP) begin
                    tap_d = '0;
                    if (phase_q == LAST_PH) begin
                        state_d = S_WAIT;
                        wait_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                        phase_d = phase_q + 1'b1;
                        base_d  = base_q + BASE_INC;
                    end
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_q == LAST_W) begin
                    state_d = S_CAPTURE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
                phase_d = '0;
                base_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A sample seen while not idle is dropped; set wins over clear.
    assign ovr_set = din_valid && (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tap_q        <= '0;
            base_q       <= '0;
            phase_q      <= '0;
            wait_q       <= '0;
            ready_q      <= 1'b1;
            mac_en_q     <= 1'b0;
            acc_q        <= 1'b0;
            capture_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            base_q       <= base_d;
            phase_q      <= phase_d;
            wait_q       <= wait_d;
            ready_q      <= (state_d == S_IDLE);
            mac_en_q     <= (state_d == S_MAC);
            // Only the first MAC of phase 0 loads, clearing the accumulator.
            acc_q        <= (state_d == S_MAC) &&
                            !((state_q == S_IDLE) && (phase_q == '0));
            capture_q    <= (state_d == S_CAPTURE);
            dout_valid_q <= capture_q;
            overrun_q    <= ovr_set || (overrun_q && !overrun_clr);
        end
    end

    assign din_ready  = ready_q;
    assign mac_en     = mac_en_q;
    assign tap_addr   = tap_q;
    assign dsp_acc    = acc_q;
    assign phase      = phase_q;
    assign capture    = capture_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    // Base register stands in for phase*BANK_LEN; forced to 0 outside MAC.
    assign coef_addr  = mac_en_q ? (base_q + NT_LOG2'(tap_q)) : '0;

endmodule

// File: tb/tb_fir_poly_sched.sv
// tb_fir_poly_sched: self-checking bench for fir_poly_sched with a
// cycle-indexed expectation model and directed plus random stimulus.
module tb_fir_poly_sched;

    localparam int NT   = 120;
    localparam int MM   = 20;
    localparam int BL   = 6;
    localparam int DL   = 3;
    localparam int MAXC = 4000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din_valid;
    logic       din_ready;
    logic       mac_en;
    logic [2:0] tap_addr;
    logic [6:0] coef_addr;
    logic       dsp_acc;
    logic [4:0] phase;
    logic       capture;
    logic       dout_valid;
    logic       overrun;
    logic       overrun_clr;

    fir_poly_sched #(
        .N_TAPS  (NT),
        .M       (MM),
        .BANK_LEN(BL),
        .DSP_LAT (DL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .mac_en     (mac_en),
        .tap_addr   (tap_addr),
        .coef_addr  (coef_addr),
        .dsp_acc    (dsp_acc),
        .phase      (phase),
        .capture    (capture),
        .dout_valid (dout_valid),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // expected value of every output, indexed by cycle number
    bit e_rdy [MAXC];
    bit e_mac [MAXC];
    int e_tap [MAXC];
    int e_coef[MAXC];
    bit e_acc [MAXC];
    int e_ph  [MAXC];
    bit e_cap [MAXC];
    bit e_dv  [MAXC];
    bit e_ovr [MAXC];

    int m_ph       = 0;
    int m_ready_at = 0;
    bit m_ovr      = 1'b0;

    bit [NT-1:0] seen;
    int mac_cnt = 0;
    int dv_q[$];

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s cyc=%0d got=%0d exp=%0d",
                         nm, cyc, got, exp);
        end
    endtask

    task automatic mdl_accept(input int c);
        int end_c;
        int nph;
        for (int k = 0; k < BL; k++) begin
            int x = c + 1 + k;
            if (x < MAXC) begin
                e_mac[x]  = 1'b1;
                e_tap[x]  = k;
                e_coef[x] = m_ph * BL + k;
                e_acc[x]  = !(m_ph == 0 && k == 0);
            end
        end
        if (m_ph != MM - 1) begin
            end_c = c + BL + 1;
            nph   = m_ph + 1;
        end else begin
            end_c = c + BL + DL + 2;
            nph   = 0;
            if (end_c < MAXC) begin
                e_cap[end_c - 1] = 1'b1;
                e_dv[end_c]      = 1'b1;
            end
        end
        for (int x = c + 1; x < end_c && x < MAXC; x++) begin
            e_rdy[x] = 1'b0;
            e_ph[x]  = m_ph;
        end
        for (int x = end_c; x < MAXC; x++) e_ph[x] = nph;
        m_ph       = nph;
        m_ready_at = end_c;
    endtask

    task automatic mdl_step(input int c, input bit dv, input bit clr);
        bit set;
        set = 1'b0;
        if (dv) begin
            if (c >= m_ready_at) mdl_accept(c);
            else set = 1'b1;
        end
        m_ovr = set || (m_ovr && !clr);
        if (c + 1 < MAXC) e_ovr[c + 1] = m_ovr;
    endtask

    task automatic mdl_reset(input int c);
        for (int x = c; x < MAXC; x++) begin
            e_rdy[x]  = 1'b1;
            e_mac[x]  = 1'b0;
            e_tap[x]  = 0;
            e_coef[x] = 0;
            e_acc[x]  = 1'b0;
            e_ph[x]   = 0;
            e_cap[x]  = 1'b0;
            e_dv[x]   = 1'b0;
            e_ovr[x]  = 1'b0;
        end
        m_ph       = 0;
        m_ready_at = c;
        m_ovr      = 1'b0;
    endtask

    task automatic step(input bit dv, input bit clr);
        din_valid   = dv;
        overrun_clr = clr;
        mdl_step(cyc, dv, clr);
        @(posedge clk);
        #1;
        cyc++;
        din_valid   = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mdl_reset(cyc);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    function automatic int next_gap();
        return (m_ph == MM - 1) ? BL + DL + 2 : BL + 1;
    endfunction

    task automatic send(input int gap);
        step(1'b1, 1'b0);
        repeat (gap - 1) step(1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            chk("din_ready", int'(din_ready), int'(e_rdy[cyc]));
            chk("mac_en", int'(mac_en), int'(e_mac[cyc]));
            chk("tap_addr", int'(tap_addr), e_tap[cyc]);
            chk("coef_addr", int'(coef_addr), e_coef[cyc]);
            chk("dsp_acc", int'(dsp_acc), int'(e_acc[cyc]));
            chk("phase", int'(phase), e_ph[cyc]);
            chk("capture", int'(capture), int'(e_cap[cyc]));
            chk("dout_valid", int'(dout_valid), int'(e_dv[cyc]));
            chk("overrun", int'(overrun), int'(e_ovr[cyc]));
            if (mac_en) begin
                mac_cnt++;
                if (int'(coef_addr) < NT) seen[coef_addr] = 1'b1;
            end
            if (dout_valid) dv_q.push_back(cyc);
        end
    end

    initial begin
        int t;
        int n0;
        for (int i = 0; i < MAXC; i++) e_rdy[i] = 1'b1;
        rst_n       = 1'b1;
        din_valid   = 1'b0;
        overrun_clr = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        do_reset();

        // reset values, then a quiet stretch
        chk("rst_ready", int'(din_ready), 1);
        chk("rst_phase", int'(phase), 0);
        chk("rst_coef", int'(coef_addr), 0);
        mac_cnt = 0;
        repeat (10) step(1'b0, 1'b0);
        chk("idle_no_mac", mac_cnt, 0);

        // single sample at phase 0
        t = cyc;
        step(1'b1, 1'b0);
        chk("s1_acc_first", int'(dsp_acc), 0);
        chk("s1_coef_first", int'(coef_addr), 0);
        repeat (5) step(1'b0, 1'b0);
        chk("s1_coef_last", int'(coef_addr), 5);
        chk("s1_acc_last", int'(dsp_acc), 1);
        step(1'b0, 1'b0);
        chk("s1_ready_t7", int'(din_ready), 1);
        chk("s1_phase_t7", int'(phase), 1);
        chk("s1_t7", cyc - t, 7);

        // full decimation at 12-cycle spacing
        do_reset();
        seen    = '0;
        mac_cnt = 0;
        for (int s = 0; s < MM - 1; s++) send(12);
        t = cyc;
        step(1'b1, 1'b0);
        repeat (9) step(1'b0, 1'b0);
        chk("fd_capture_t10", int'(capture), 1);
        step(1'b0, 1'b0);
        chk("fd_dv_t11", int'(dout_valid), 1);
        chk("fd_phase_wrap", int'(phase), 0);
        chk("fd_sweep", (seen == {NT{1'b1}}) ? 1 : 0, 1);
        chk("fd_mac_cnt", mac_cnt, NT);
        step(1'b1, 1'b0);
        chk("fd_next_acc", int'(dsp_acc), 0);
        repeat (6) step(1'b0, 1'b0);

        // overrun set, clear, and set-beats-clear
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("ov_set", int'(overrun), 1);
        chk("ov_tap", int'(tap_addr), 3);
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("ov_clr", int'(overrun), 0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk("ov_set_wins", int'(overrun), 1);
        step(1'b0, 1'b1);
        chk("ov_clr2", int'(overrun), 0);
        repeat (3) step(1'b0, 1'b0);

        // reset during WAIT of the final phase
        do_reset();
        for (int s = 0; s < MM - 1; s++) send(BL + 1);
        step(1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b0);
        rst_n = 1'b0;
        mdl_reset(cyc);
        #1;
        chk("mr_phase", int'(phase), 0);
        chk("mr_ready", int'(din_ready), 1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        n0 = dv_q.size();
        repeat (12) step(1'b0, 1'b0);
        chk("mr_no_dv", dv_q.size(), n0);
        for (int s = 0; s < MM; s++) send(next_gap());
        step(1'b0, 1'b0);
        chk("mr_next_out", dv_q.size(), n0 + 1);

        // maximum rate, three outputs
        n0 = dv_q.size();
        for (int s = 0; s < 3 * MM; s++) send(next_gap());
        step(1'b0, 1'b0);
        chk("mx_outputs", dv_q.size() - n0, 3);
        if (dv_q.size() >= n0 + 3) begin
            chk("mx_gap1", dv_q[n0 + 1] - dv_q[n0], 144);
            chk("mx_gap2", dv_q[n0 + 2] - dv_q[n0 + 1], 144);
        end
        chk("mx_no_ovr", int'(overrun), 0);

        // random traffic, including drops and clears
        repeat (400)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        repeat (15) step(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
